// File: rtl/div_if.sv
// rtl/div_if.sv - request/result bundle between the EX stage and the divider
// Ports (master = EX-stage issue logic, slave = div_unit):
//   start, op, dividend, divisor, flush : issue side, driven by master
//   divres, div_ready, busy             : result side, driven by slave
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic [WIDTH-1:0] divres;
  logic             div_ready;
  logic             busy;

  modport master (
    output start, op, dividend, divisor, flush,
    input  divres, div_ready, busy
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output divres, div_ready, busy
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : div_if.slave (start/op/dividend/divisor/flush in,
//                divres/div_ready/busy out)
// op encoding: 00=DIV, 01=DIVU, 10=REM, 11=REMU (op[0]=unsigned, op[1]=remainder)
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             sel_rem_r;
  logic             qsign_r, rsign_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH:0]   acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] divres_r;

  // Issue-side decode
  logic             in_signed, dvd_neg, dvs_neg, div_zero, ovf, special, accept;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, special_res;

  assign in_signed = ~bus.op[0];
  assign dvd_neg   = in_signed & bus.dividend[WIDTH-1];
  assign dvs_neg   = in_signed & bus.divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag   = dvs_neg ? -bus.divisor : bus.divisor;
  assign div_zero  = (bus.divisor == '0);
  assign ovf       = in_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (bus.divisor == '1);
  assign special   = div_zero | ovf;
  assign accept    = (state == IDLE) & bus.start & ~bus.flush;

  // Divide-by-zero takes precedence over overflow; overflow quotient is the
  // most negative value and its remainder is zero.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = bus.op[1] ? bus.dividend : '1;
    else
      special_res = bus.op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One restoring step: the shifted accumulator is WIDTH+1 bits so the
  // compare/subtract against the divisor magnitude cannot overflow.
  logic [WIDTH:0]   acc_sh, acc_sub, acc_nxt;
  logic [WIDTH-1:0] q_nxt, quo_fix, rem_fix, result;
  logic             ge;

  always_comb begin
    acc_sh  = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
    acc_sub = acc_sh - {1'b0, dvsr_r};
    ge      = (acc_sh >= {1'b0, dvsr_r});
    acc_nxt = ge ? acc_sub : acc_sh;
    q_nxt   = {q_r[WIDTH-2:0], ge};
    quo_fix = qsign_r ? -q_nxt : q_nxt;
    rem_fix = rsign_r ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    result  = sel_rem_r ? rem_fix : quo_fix;
  end

  // After a restoring step the accumulator is below the divisor, so its top
  // bit never feeds the next shift.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_r[WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything, including a same-cycle start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt_r == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_rem_r <= 1'b0;
      qsign_r   <= 1'b0;
      rsign_r   <= 1'b0;
      q_r       <= '0;
      dvsr_r    <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      divres_r  <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        if (special) begin
          divres_r <= special_res;
        end else begin
          sel_rem_r <= bus.op[1];
          qsign_r   <= dvd_neg ^ dvs_neg;
          rsign_r   <= dvd_neg;
          q_r       <= dvd_mag;
          dvsr_r    <= dvs_mag;
          acc_r     <= '0;
          cnt_r     <= CW'(WIDTH - 1);
        end
      end else if (state == CALC) begin
        acc_r <= acc_nxt;
        q_r   <= q_nxt;
        cnt_r <= cnt_r - CW'(1);
        if (cnt_r == '0) divres_r <= result;
      end
    end
  end

  assign bus.divres    = divres_r;
  assign bus.div_ready = (state == DONE);
  assign bus.busy      = (state == CALC) | ((state == IDLE) & bus.start);
endmodule
